// File: rtl/rr_arb_8to1.sv
// rtl/rr_arb_8to1.sv - round-robin arbiter and sequencer for a shared 8:1 single-bit select datapath
//
// Grants the datapath to one of eight requesters at a time. Priority rotates so
// that the most recent owner always has the lowest priority. A hold limit
// forces the grant to move on once another requester is waiting.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles while another request is pending (2..256)
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   req    in   [7:0] request lines, req[k] held high while requester k wants the datapath
//   i      in   [7:0] data bits, i[k] sourced by requester k
//   gnt    out  [7:0] one-hot grant (registered)
//   s      out  [2:0] index of the current owner (registered)
//   v      out  grant valid, high exactly when gnt != 0 (registered)
//   y      out  muxed data, y = v & i[s] (combinational)
module rr_arb_8to1 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] i,
  output logic [7:0] gnt,
  output logic [2:0] s,
  output logic       v,
  output logic       y
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [2:0]    ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    gnt_n;
  logic [2:0]    s_n;
  logic          v_n;

  logic [3:0]    win_all;
  logic [3:0]    win_ex;
  logic          issue;
  logic [2:0]    issue_idx;

  // Returns {found, index} of the first set bit of m in circular order
  // starting at p. Scanning offsets from far to near lets the nearest hit win.
  function automatic logic [3:0] rr_find(input logic [7:0] m, input logic [2:0] p);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'b0;
    for (int off = 7; off >= 0; off--) begin
      idx = p + 3'(off);
      if (m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    s_n       = s;
    v_n       = v;
    ptr_n     = ptr;
    cnt_n     = cnt;
    issue     = 1'b0;
    issue_idx = 3'd0;

    win_all = rr_find(req, ptr);
    // gnt is the one-hot of s while granting, so it masks the owner out
    win_ex  = rr_find(req & ~gnt, ptr);

    case (state)
      IDLE: begin
        gnt_n = 8'h00;
        v_n   = 1'b0;
        if (win_all[3]) begin
          issue     = 1'b1;
          issue_idx = win_all[2:0];
        end
      end
      GRANT: begin
        // Release and forced rotation share one path; the owner's own
        // request is excluded, so it is re-arbitrated only from IDLE or later
        if (!req[s] || (cnt == CNT_MAX && win_ex[3])) begin
          if (win_ex[3]) begin
            issue     = 1'b1;
            issue_idx = win_ex[2:0];
          end else begin
            state_n = IDLE;
            gnt_n   = 8'h00;
            v_n     = 1'b0;
          end
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 8'h00;
        v_n     = 1'b0;
      end
    endcase

    if (issue) begin
      state_n = GRANT;
      gnt_n   = 8'b1 << issue_idx;
      s_n     = issue_idx;
      v_n     = 1'b1;
      ptr_n   = issue_idx + 3'd1;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 8'h00;
      s     <= 3'd0;
      v     <= 1'b0;
      ptr   <= 3'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      s     <= s_n;
      v     <= v_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  assign y = v & i[s];

endmodule

// File: tb/tb_rr_arb_8to1.sv
// tb/tb_rr_arb_8to1.sv - self-checking bench for rr_arb_8to1 at MAX_HOLD 4 and 16
module tb_rr_arb_8to1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] i;

  logic [7:0] gnt4, gnt16;
  logic [2:0] s4, s16;
  logic       v4, v16, y4, y16;

  int errors = 0;
  int checks = 0;

  // Reference state per DUT: owner (-1 when idle), last select, rotation
  // start, and cycles owned so far in the current grant (unbounded).
  int mh[2] = '{4, 16};
  int owner[2];
  int sel[2];
  int start[2];
  int held[2];

  always #5 clk = ~clk;

  rr_arb_8to1 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .i(i),
    .gnt(gnt4), .s(s4), .v(v4), .y(y4)
  );

  rr_arb_8to1 #(.MAX_HOLD(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req), .i(i),
    .gnt(gnt16), .s(s16), .v(v16), .y(y16)
  );

  function automatic int search(input logic [7:0] m, input int p);
    for (int j = 0; j < 8; j++) begin
      if (m[(p + j) % 8]) return (p + j) % 8;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        owner[d] = -1; sel[d] = 0; start[d] = 0; held[d] = 0;
      end else if (owner[d] < 0) begin
        int w;
        w = search(req, start[d]);
        if (w >= 0) begin
          owner[d] = w; sel[d] = w; start[d] = (w + 1) % 8; held[d] = 1;
        end
      end else begin
        int w;
        logic [7:0] others;
        others = req;
        others[owner[d]] = 1'b0;
        w = search(others, start[d]);
        if (!req[owner[d]] || (held[d] >= mh[d] && w >= 0)) begin
          if (w >= 0) begin
            owner[d] = w; sel[d] = w; start[d] = (w + 1) % 8; held[d] = 1;
          end else begin
            owner[d] = -1;
          end
        end else begin
          held[d]++;
        end
      end
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      logic [7:0] eg;
      logic       ev;
      logic [7:0] og;
      logic [2:0] os;
      logic       ov, oy;
      ev = (owner[d] >= 0);
      eg = ev ? (8'h01 << owner[d]) : 8'h00;
      og = (d == 0) ? gnt4 : gnt16;
      os = (d == 0) ? s4 : s16;
      ov = (d == 0) ? v4 : v16;
      oy = (d == 0) ? y4 : y16;
      chk($sformatf("mh%0d gnt", mh[d]), og, eg);
      chk($sformatf("mh%0d s", mh[d]), {5'b0, os}, 8'(sel[d]));
      chk($sformatf("mh%0d v", mh[d]), {7'b0, ov}, {7'b0, ev});
      chk($sformatf("mh%0d y", mh[d]), {7'b0, oy}, {7'b0, ev & i[sel[d]]});
    end
  endtask

  // Apply inputs, take one clock edge, then check both DUTs against the model.
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] dat);
    rst_n = r;
    req   = rq;
    i     = dat;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    i     = 8'h00;
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; sel[d] = 0; start[d] = 0; held[d] = 0;
    end

    // Reset with every request high
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 8'hFF, 8'hFF);
      chk("reset v", {7'b0, v16}, 8'h00);
      chk("reset y", {7'b0, y16}, 8'h00);
    end
    step(1'b1, 8'hFF, 8'hFF);
    chk("first grant", gnt16, 8'h01);

    // Single requester from IDLE
    step(1'b1, 8'h00, 8'h20);
    step(1'b1, 8'h20, 8'h20);
    chk("single gnt", gnt16, 8'h20);
    chk("single s", {5'b0, s16}, 8'd5);
    chk("single y", {7'b0, y16}, 8'h01);
    step(1'b1, 8'h00, 8'h20);
    chk("single drop v", {7'b0, v16}, 8'h00);
    chk("single drop y", {7'b0, y16}, 8'h00);

    // Round-robin between 0 and 7 at MAX_HOLD 4
    step(1'b0, 8'h00, 8'h00);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 8'h81, 8'($urandom));
      chk("rr seq", gnt4, ((c / 4) % 2 == 0) ? 8'h01 : 8'h80);
    end

    // Release handover 2 -> 3 -> 5
    step(1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h04, 8'h00);
    chk("handover own2", gnt16, 8'h04);
    step(1'b1, 8'h28, 8'h00);
    chk("handover to3", gnt16, 8'h08);
    step(1'b1, 8'h20, 8'h00);
    chk("handover to5", gnt16, 8'h20);

    // Uncontended hold past MAX_HOLD, then contention rotates at once
    step(1'b0, 8'h00, 8'h00);
    for (int c = 0; c < 40; c++) begin
      step(1'b1, 8'h04, 8'($urandom));
      chk("hold gnt", gnt16, 8'h04);
    end
    step(1'b1, 8'h06, 8'h00);
    chk("hold rotate", gnt16, 8'h02);

    // Reset mid-grant
    step(1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h10, 8'hFF);
    chk("mid own4", gnt16, 8'h10);
    step(1'b0, 8'h10, 8'hFF);
    chk("mid reset v", {7'b0, v16}, 8'h00);
    step(1'b1, 8'h11, 8'hFF);
    chk("mid ptr0", gnt16, 8'h01);

    // Randomized traffic: requesters hold their lines for a while
    req = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] nr;
      nr = req;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 9) == 0) nr[k] = ~nr[k];
      end
      step(($urandom_range(0, 199) != 0), nr, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
